fifo_drain: RTL and testbench

Downstream stage of the 32-bit `fifo`: it snoops the FIFO write strobe to track occupancy, issues `signal_oe` reads while words are present and it has buffer space, and captures `data_out` one cycle after each read. It re-presents the words as a valid/ready stream framed into fixed-length bursts. Placed in the same cosimulation top as `fifo`, with its stream side driven and checked from MyHDL.

---
 rtl/fifo_drain_pkg.sv | 23 ++
 rtl/fifo_drain_skid.sv | 89 ++++++++
 rtl/fifo_drain.sv | 135 +++++++++++++
 tb/tb_fifo_drain.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_drain_pkg.sv
// fifo_drain_pkg: shared defaults, debug state encoding and width helper for fifo_drain.
//   DATA_W_DEF    - default stream/FIFO data width
//   DEPTH_DEF     - default FIFO capacity in words
//   BURST_LEN_DEF - default words per burst
//   state_e       - derived activity state, exposed for debug only
//   occ_width()   - bits needed to hold an occupancy count of 0..depth
package fifo_drain_pkg;

  localparam int unsigned DATA_W_DEF    = 32;
  localparam int unsigned DEPTH_DEF     = 16;
  localparam int unsigned BURST_LEN_DEF = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    HOLD   = 2'd2
  } state_e;

  function automatic int unsigned occ_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_drain_skid.sv
// fifo_drain_skid: two-entry valid/ready output buffer.
// Ports:
//   i_clk, i_rst  - clock and synchronous active-high reset
//   i_push        - write i_push_data into the buffer this cycle
//   i_push_data   - word to store
//   o_valid       - head word present
//   o_data        - head word; held stable until it is transferred
//   i_ready       - consumer accepts the head word
//   o_count       - number of stored words (0..2)
// A push and a pop may happen in the same cycle. The caller guarantees that it never
// pushes into a full buffer without popping in that cycle.
module fifo_drain_skid
  import fifo_drain_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_push_data,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  input  logic              i_ready,
  output logic [1:0]        o_count
);

  logic [DATA_W-1:0] r_head;
  logic [DATA_W-1:0] r_tail;
  logic [1:0]        r_count;

  logic [DATA_W-1:0] w_head_nxt;
  logic [DATA_W-1:0] w_tail_nxt;
  logic [1:0]        w_count_nxt;
  logic              w_pop;

  assign w_pop = (r_count != 2'd0) && i_ready;

  always_comb begin
    w_head_nxt  = r_head;
    w_tail_nxt  = r_tail;
    w_count_nxt = r_count;
    case ({i_push, w_pop})
      2'b10: begin
        if (r_count == 2'd0) begin
          w_head_nxt  = i_push_data;
          w_count_nxt = 2'd1;
        end else if (r_count == 2'd1) begin
          w_tail_nxt  = i_push_data;
          w_count_nxt = 2'd2;
        end
      end
      2'b01: begin
        // Head only moves when a second word exists; otherwise it keeps the last value
        // while o_valid is low.
        if (r_count == 2'd2) begin
          w_head_nxt = r_tail;
        end
        w_count_nxt = r_count - 2'd1;
      end
      2'b11: begin
        if (r_count == 2'd1) begin
          w_head_nxt = i_push_data;
        end else begin
          w_head_nxt = r_tail;
          w_tail_nxt = i_push_data;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= 2'd0;
    end else begin
      r_head  <= w_head_nxt;
      r_tail  <= w_tail_nxt;
      r_count <= w_count_nxt;
    end
  end

  assign o_valid = (r_count != 2'd0);
  assign o_data  = r_head;
  assign o_count = r_count;

endmodule

// File: rtl/fifo_drain.sv
// fifo_drain: drains a 32-bit FIFO into a burst-framed valid/ready stream.
// Ports:
//   clk, rst    - sole clock; synchronous active-high reset
//   signal_wr   - snooped FIFO write strobe (counts words entering the FIFO)
//   data_out    - FIFO read data, valid the cycle after a signal_oe cycle
//   signal_oe   - FIFO read strobe, one word per high cycle
//   m_data      - stream data
//   m_valid     - stream word present
//   m_ready     - consumer accepts
//   m_last      - last word of a BURST_LEN-word burst, qualified by m_valid
//   occupancy   - tracked FIFO word count 0..DEPTH
//   overflow    - sticky: a write arrived while occupancy == DEPTH
//   dbg_state   - derived IDLE/STREAM/HOLD state, debug only
module fifo_drain
  import fifo_drain_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned DEPTH     = DEPTH_DEF,
  parameter int unsigned BURST_LEN = BURST_LEN_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         signal_wr,
  input  logic [DATA_W-1:0]            data_out,
  output logic                         signal_oe,
  output logic [DATA_W-1:0]            m_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic                         m_last,
  output logic [occ_width(DEPTH)-1:0]  occupancy,
  output logic                         overflow,
  output state_e                       dbg_state
);

  localparam int unsigned OCC_W  = occ_width(DEPTH);
  localparam int unsigned BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  localparam logic [OCC_W-1:0]  OCC_FULL  = OCC_W'(DEPTH);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);

  logic [OCC_W-1:0]  r_occ;
  logic              r_overflow;
  logic              r_inflight;
  logic [BEAT_W-1:0] r_beat;

  logic [OCC_W-1:0]  w_occ_nxt;
  logic              w_inc;
  logic              w_pop;
  logic [1:0]        w_skid_count;
  logic [2:0]        w_pending;

  // ---------------------------------------------------------------------------
  // Output buffer. A read issued in cycle t is captured at the end of t+1, which is
  // exactly the cycle r_inflight is high.
  // ---------------------------------------------------------------------------
  fifo_drain_skid #(
    .DATA_W (DATA_W)
  ) u_skid (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_push      (r_inflight),
    .i_push_data (data_out),
    .o_valid     (m_valid),
    .o_data      (m_data),
    .i_ready     (m_ready),
    .o_count     (w_skid_count)
  );

  assign w_pop = m_valid && m_ready;

  // ---------------------------------------------------------------------------
  // Read issue: never commit more words than the buffer can hold. The pop of the
  // current cycle frees a slot in time for a read issued now, so m_ready rising
  // re-opens reads in the same cycle.
  // ---------------------------------------------------------------------------
  assign w_pending = {1'b0, w_skid_count} + {2'b00, r_inflight};
  assign signal_oe = (r_occ != '0) && (w_pending < (3'd2 + {2'b00, w_pop}));

  // ---------------------------------------------------------------------------
  // Occupancy tracking and sticky overflow
  // ---------------------------------------------------------------------------
  assign w_inc = signal_wr && (r_occ != OCC_FULL);

  always_comb begin
    w_occ_nxt = r_occ;
    case ({w_inc, signal_oe})
      2'b10:   w_occ_nxt = r_occ + OCC_W'(1);
      2'b01:   w_occ_nxt = r_occ - OCC_W'(1);
      default: w_occ_nxt = r_occ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_occ      <= '0;
      r_overflow <= 1'b0;
      r_inflight <= 1'b0;
    end else begin
      r_occ      <= w_occ_nxt;
      r_inflight <= signal_oe;
      if (signal_wr && (r_occ == OCC_FULL)) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Burst framing
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_beat <= '0;
    end else if (w_pop) begin
      r_beat <= (r_beat == BEAT_LAST) ? '0 : r_beat + BEAT_W'(1);
    end
  end

  assign m_last    = m_valid && (r_beat == BEAT_LAST);
  assign occupancy = r_occ;
  assign overflow  = r_overflow;

  // ---------------------------------------------------------------------------
  // Debug state. A read in flight counts as activity, so IDLE means nothing is
  // anywhere in the drain path.
  // ---------------------------------------------------------------------------
  always_comb begin
    dbg_state = STREAM;
    if ((r_occ == '0) && (w_skid_count == 2'd0) && !r_inflight) begin
      dbg_state = IDLE;
    end else if ((w_skid_count == 2'd2) && !m_ready) begin
      dbg_state = HOLD;
    end
  end

endmodule

// File: tb/tb_fifo_drain.sv
module tb_fifo_drain;
  import fifo_drain_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned DP = 16;
  localparam int unsigned BL = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          signal_wr;
  logic [DW-1:0] data_out;
  logic          signal_oe;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_last;
  logic [4:0]    occupancy;
  logic          overflow;
  state_e        dbg_state;

  fifo_drain #(
    .DATA_W    (DW),
    .DEPTH     (DP),
    .BURST_LEN (BL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .signal_wr (signal_wr),
    .data_out  (data_out),
    .signal_oe (signal_oe),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_last    (m_last),
    .occupancy (occupancy),
    .overflow  (overflow),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference: the upstream FIFO contents and the expected stream, in write order.
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] next_dout = '0;
  logic [DW-1:0] wr_data = '0;
  int unsigned   n_xfer = 0;
  logic          mdl_ovf = 1'b0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;
  logic          drv_rst = 1'b1;

  // Per-cycle samples taken by the driver
  logic          s_oe, s_valid, s_last, s_ovf, s_xfer;
  logic [DW-1:0] s_data;
  logic [4:0]    s_occ;
  state_e        s_state;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin : monitor
    logic [DW-1:0] w;
    logic          full;
    if (rst) begin
      fifo_q.delete();
      exp_q.delete();
      n_xfer     = 0;
      mdl_ovf    = 1'b0;
      prev_stall = 1'b0;
    end else begin
      check("occupancy", 64'(occupancy), 64'(fifo_q.size()));
      check("overflow", 64'(overflow), 64'(mdl_ovf));
      if (prev_stall) begin
        check("hold_valid", 64'(m_valid), 64'd1);
        check("hold_data", 64'(m_data), 64'(prev_data));
        check("hold_last", 64'(m_last), 64'(prev_last));
      end
      if (m_valid) begin
        check("valid_has_word", 64'(exp_q.size() != 0), 64'd1);
      end else begin
        check("last_unqualified", 64'(m_last), 64'd0);
      end
      if (m_valid && m_ready && (exp_q.size() != 0)) begin
        w = exp_q.pop_front();
        check("m_data", 64'(m_data), 64'(w));
        check("m_last", 64'(m_last), 64'((n_xfer % BL) == (BL - 1)));
        n_xfer++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      full = (fifo_q.size() == DP);
      if (signal_oe) begin
        check("read_nonempty", 64'(fifo_q.size() != 0), 64'd1);
        if (fifo_q.size() != 0) next_dout = fifo_q.pop_front();
      end
      if (signal_wr) begin
        if (!full) begin
          fifo_q.push_back(wr_data);
          exp_q.push_back(wr_data);
        end else begin
          mdl_ovf = 1'b1;
        end
      end
    end
  end

  task automatic step(input logic wr, input logic [DW-1:0] d, input logic rdy);
    @(posedge clk);
    #1;
    rst       = drv_rst;
    signal_wr = wr;
    wr_data   = d;
    m_ready   = rdy;
    data_out  = next_dout;
    @(negedge clk);
    s_oe    = signal_oe;
    s_valid = m_valid;
    s_last  = m_last;
    s_ovf   = overflow;
    s_data  = m_data;
    s_occ   = occupancy;
    s_state = dbg_state;
    s_xfer  = m_valid && rdy;
  endtask

  // Leaves the DUT in the first cycle after rst deasserts.
  task automatic do_reset();
    drv_rst = 1'b1;
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    drv_rst = 1'b0;
    step(1'b0, '0, 1'b0);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1);
  endtask

  initial begin : driver
    int oe_cnt, first_oe, last_oe, first_val, xf, first_xf, last_xf, occ16_at, ovf_at;
    logic [7:0]    last_mask;
    logic [DW-1:0] d1 [10];
    logic          v1 [10];
    logic [DW-1:0] word0;
    logic [DW-1:0] w;

    rst       = 1'b1;
    signal_wr = 1'b0;
    m_ready   = 1'b0;
    data_out  = '0;

    // Reset values (sampled while rst is still held)
    drv_rst = 1'b1;
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    check("rst_oe", 64'(s_oe), 64'd0);
    check("rst_valid", 64'(s_valid), 64'd0);
    check("rst_last", 64'(s_last), 64'd0);
    check("rst_ovf", 64'(s_ovf), 64'd0);
    check("rst_data", 64'(s_data), 64'd0);
    check("rst_occ", 64'(s_occ), 64'd0);
    drv_rst = 1'b0;
    step(1'b0, '0, 1'b1);
    check("post_rst_oe", 64'(s_oe), 64'd0);
    check("post_rst_valid", 64'(s_valid), 64'd0);
    check("post_rst_idle", 64'(s_state), 64'(IDLE));

    // Three writes, consumer always ready
    oe_cnt = 0; first_oe = -1; last_oe = -1; first_val = -1;
    for (int i = 0; i < 10; i++) begin
      case (i)
        0: step(1'b1, 32'h11, 1'b1);
        1: step(1'b1, 32'h22, 1'b1);
        2: step(1'b1, 32'h33, 1'b1);
        default: step(1'b0, '0, 1'b1);
      endcase
      d1[i] = s_data;
      v1[i] = s_valid;
      if (s_oe) begin
        oe_cnt++;
        if (first_oe < 0) first_oe = i;
        last_oe = i;
      end
      if (s_valid && first_val < 0) first_val = i;
    end
    check("t1_oe_count", 64'(oe_cnt), 64'd3);
    check("t1_first_oe", 64'(first_oe), 64'd1);
    check("t1_last_oe", 64'(last_oe), 64'd3);
    check("t1_first_valid", 64'(first_val), 64'd3);
    check("t1_data0", 64'({v1[3], d1[3]}), {31'd0, 1'b1, 32'h11});
    check("t1_data1", 64'({v1[4], d1[4]}), {31'd0, 1'b1, 32'h22});
    check("t1_data2", 64'({v1[5], d1[5]}), {31'd0, 1'b1, 32'h33});
    check("t1_occ_end", 64'(s_occ), 64'd0);

    // Eight writes, bursts of four
    do_reset();
    xf = 0; last_mask = '0;
    for (int i = 0; i < 16; i++) begin
      step(i < 8, $urandom, 1'b1);
      if (s_xfer) begin
        if (xf < 8) last_mask[xf] = s_last;
        xf++;
      end
    end
    check("t2_xfers", 64'(xf), 64'd8);
    check("t2_last_mask", 64'(last_mask), 64'h88);

    // Six writes against a stalled consumer, then release
    do_reset();
    oe_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      w = $urandom;
      if (i == 0) word0 = w;
      step(i < 6, w, 1'b0);
      if (s_oe) oe_cnt++;
    end
    check("t3_reads", 64'(oe_cnt), 64'd2);
    check("t3_stuck_valid", 64'(s_valid), 64'd1);
    check("t3_stuck_data", 64'(s_data), 64'(word0));
    check("t3_occ", 64'(s_occ), 64'd4);
    check("t3_hold", 64'(s_state), 64'(HOLD));
    xf = 0; first_xf = -1; last_xf = -1;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, '0, 1'b1);
      if (s_xfer) begin
        xf++;
        if (first_xf < 0) first_xf = i;
        last_xf = i;
      end
    end
    check("t3_xfers", 64'(xf), 64'd6);
    check("t3_no_gaps", 64'(last_xf - first_xf), 64'd5);

    // Overflow: fill the counter with the consumer stalled
    do_reset();
    occ16_at = -1; ovf_at = -1;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, $urandom, 1'b0);
      if (s_occ == 5'd16 && occ16_at < 0) occ16_at = i;
      if (s_ovf && ovf_at < 0) ovf_at = i;
    end
    check("t4_reached_full", 64'(occ16_at >= 0), 64'd1);
    check("t4_ovf_timing", 64'(ovf_at), 64'(occ16_at + 1));
    check("t4_occ_sat", 64'(s_occ), 64'd16);
    drain(30);
    check("t4_ovf_sticky", 64'(s_ovf), 64'd1);
    check("t4_occ_drained", 64'(s_occ), 64'd0);
    do_reset();
    check("t4_ovf_cleared", 64'(s_ovf), 64'd0);

    // Simultaneous write and read at occupancy 5
    for (int i = 0; i < 10; i++) step(i < 7, $urandom, 1'b0);
    check("t5_occ_before", 64'(s_occ), 64'd5);
    step(1'b1, $urandom, 1'b1);
    check("t5_oe", 64'(s_oe), 64'd1);
    step(1'b0, '0, 1'b0);
    check("t5_occ_after", 64'(s_occ), 64'd5);
    drain(30);

    // Reset with a full buffer and a read being issued
    do_reset();
    for (int i = 0; i < 8; i++) step(i < 5, $urandom, 1'b0);
    drv_rst = 1'b1;
    step(1'b0, '0, 1'b1);
    check("t6_pre_oe", 64'(s_oe), 64'd1);
    check("t6_pre_valid", 64'(s_valid), 64'd1);
    drv_rst = 1'b0;
    step(1'b0, '0, 1'b1);
    check("t6_oe", 64'(s_oe), 64'd0);
    check("t6_valid", 64'(s_valid), 64'd0);
    check("t6_data", 64'(s_data), 64'd0);
    check("t6_occ", 64'(s_occ), 64'd0);
    xf = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, '0, 1'b1);
      if (s_valid || s_oe) xf++;
    end
    check("t6_no_stale", 64'(xf), 64'd0);

    // Randomized traffic with varying consumer pressure and one mid-run reset
    do_reset();
    for (int i = 0; i < 900; i++) begin
      int unsigned pr;
      pr = ((i / 64) % 3 == 0) ? 20 : (((i / 64) % 3 == 1) ? 60 : 100);
      drv_rst = (i == 450) || (i == 451);
      step(($urandom % 100) < 55, $urandom, ($urandom % 100) < pr);
    end
    drv_rst = 1'b0;
    drain(60);
    check("final_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
